// File: rtl/ahb_fifo_pkg.sv
// Shared definitions for the AHB FIFO mailbox slave.
// Contents:
//   - HTRANS_* and HRESP_* bus encodings.
//   - Register map offsets, decoded from haddr[3:2].
//   - Slave FSM state encoding.
//   - STATUS bit offsets, counted upward from the bit just above the count field.
//   - CTRL bit positions.
//   - Small helpers for transfer qualification and the legal hsize value.
package ahb_fifo_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_UNMAP  = 2'd3
  } reg_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // STATUS = {ovf, udf, af, full, empty, count}; these offsets sit above count.
  localparam int unsigned STAT_EMPTY_OFS = 0;
  localparam int unsigned STAT_FULL_OFS  = 1;
  localparam int unsigned STAT_AF_OFS    = 2;
  localparam int unsigned STAT_UDF_OFS   = 3;
  localparam int unsigned STAT_OVF_OFS   = 4;

  localparam int unsigned CTRL_FLUSH_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT   = 1;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic is_xfer(input logic [1:0] trans);
    is_xfer = 1'b0;
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: is_xfer = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  is_xfer = 1'b0;
      default:                   is_xfer = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] hsize_for(input int unsigned dwidth);
    hsize_for = 3'($clog2(dwidth / 8));
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk_i    : clock.
//   rst_ni   : async active-low reset; clears pointers and count.
//   push_i   : push request; ignored while full.
//   pop_i    : pop request; ignored while empty.
//   flush_i  : empties the FIFO; wins over a same-cycle push or pop.
//   wdata_i  : data to push.
//   rdata_o  : current head entry, valid whenever the FIFO is not empty.
//   count_o  : occupancy, AWIDTH+1 bits wide.
//   full_o   : FIFO full.
//   empty_o  : FIFO empty.
module sync_fifo_core #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o,
  output logic [AWIDTH:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] rptr_q, rptr_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic              do_push, do_pop;

  // Count can only reach DEPTH, so its MSB alone marks full.
  assign full_o  = cnt_q[AWIDTH];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AWIDTH'(1);
      if (do_pop)  rptr_d = rptr_q + AWIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AWIDTH+1)'(1);
        2'b01:   cnt_d = cnt_q - (AWIDTH+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; only pointer-covered entries are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ahb_fifo_slave_v2.sv
// AHB-Lite slave fronting a synchronous FIFO used as a streaming mailbox.
//
// Register map, decoded from haddr[3:2]:
//   0  DATA    read/write  write pushes, read pops.
//   1  STATUS  read only
//   2  CTRL    write only  bit0 flush, bit1 clear ovf/udf.
//   3  unmapped
//
// Ports:
//   hclk, hreset       : clock; async active-low reset.
//   hsel, haddr        : AHB address-phase inputs.
//   htrans, hwrite     : AHB address-phase inputs.
//   hsize, hready      : AHB address-phase inputs.
//   hwdata             : write data, valid in the data phase.
//   hready_out, hresp  : slave response.
//   hrdata             : read data.
//   fifo_count         : FIFO occupancy.
//   irq_af             : almost full.
//   irq_ne             : not empty.
module ahb_fifo_slave_v2
  import ahb_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned AWIDTH     = 4,
  parameter int unsigned STALL_MODE = 1,
  parameter int unsigned WAIT_MAX   = 16,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DWIDTH-1:0] hrdata,
  output logic [AWIDTH:0]   fifo_count,
  output logic              irq_af,
  output logic              irq_ne
);

  localparam int unsigned     WCW       = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(WAIT_MAX - 1);
  localparam logic [2:0]      HSIZE_OK  = hsize_for(DWIDTH);
  localparam logic [AWIDTH:0] AF_THR    = (AWIDTH+1)'(AF_LEVEL);

  state_e           state_q, state_d;
  reg_sel_e         reg_q, reg_d;
  logic             write_q, write_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic              push, pop, flush;
  logic [DWIDTH-1:0] head;
  logic [AWIDTH:0]   count;
  logic              full, empty;

  logic              acc, dec_err, blocked;
  logic              ready_c;
  logic [1:0]        resp_c;
  logic [DWIDTH-1:0] rdata_c, stat_word;

  logic unused_addr;
  assign unused_addr = ^haddr[31:4];

  sync_fifo_core #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_fifo (
    .clk_i   (hclk),
    .rst_ni  (hreset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (hwdata),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Address-phase qualification and decode errors known before the data phase.
  always_comb begin
    acc     = hsel && hready && is_xfer(htrans);
    dec_err = (haddr[3:2] == REG_UNMAP)
           || (hwrite && (haddr[3:2] == REG_STATUS))
           || (!hwrite && (haddr[3:2] == REG_CTRL))
           || (hsize != HSIZE_OK)
           || (haddr[1:0] != 2'b00);
  end

  always_comb begin
    stat_word = '0;
    stat_word[AWIDTH:0]                      = count;
    stat_word[AWIDTH + 1 + STAT_EMPTY_OFS]   = empty;
    stat_word[AWIDTH + 1 + STAT_FULL_OFS]    = full;
    stat_word[AWIDTH + 1 + STAT_AF_OFS]      = irq_af;
    stat_word[AWIDTH + 1 + STAT_UDF_OFS]     = udf_q;
    stat_word[AWIDTH + 1 + STAT_OVF_OFS]     = ovf_q;
  end

  // Full/empty is judged in the data phase, because the previous transfer
  // may push or pop on the same edge that accepts this one.
  assign blocked = (reg_q == REG_DATA) && (write_q ? full : empty);

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    write_d = write_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    ready_c = 1'b1;
    resp_c  = HRESP_OKAY;
    rdata_c = '0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_DATA, ST_WAIT: begin
        if (blocked) begin
          ready_c = 1'b0;
          if (STALL_MODE == 0) begin
            // No stalling: this cycle doubles as the first ERROR cycle.
            resp_c  = HRESP_ERROR;
            state_d = ST_ERR2;
            ovf_d   = ovf_q | write_q;
            udf_d   = udf_q | !write_q;
          end else if ((state_q == ST_WAIT && wcnt_q >= WAIT_LAST) ||
                       (state_q == ST_DATA && WAIT_MAX <= 1)) begin
            // Last permitted wait cycle: give up and report.
            state_d = ST_ERR1;
            ovf_d   = ovf_q | write_q;
            udf_d   = udf_q | !write_q;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = (state_q == ST_DATA) ? WCW'(1) : wcnt_q + WCW'(1);
          end
        end else begin
          case (reg_q)
            REG_DATA: begin
              if (write_q) begin
                push = 1'b1;
              end else begin
                pop     = 1'b1;
                rdata_c = head;
              end
            end
            REG_STATUS: rdata_c = stat_word;
            REG_CTRL: begin
              flush = hwdata[CTRL_FLUSH_BIT];
              if (hwdata[CTRL_CLR_BIT]) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ERR1: begin
        ready_c = 1'b0;
        resp_c  = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: resp_c = HRESP_ERROR;
      default: state_d = ST_IDLE;
    endcase

    // Any cycle that completes (ready high) may accept the next address phase.
    if (ready_c) begin
      if (acc) begin
        state_d = dec_err ? ST_ERR1 : ST_DATA;
        reg_d   = reg_sel_e'(haddr[3:2]);
        write_d = hwrite;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q <= ST_IDLE;
      reg_q   <= REG_DATA;
      write_q <= 1'b0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      write_q <= write_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign hready_out = ready_c;
  assign hresp      = resp_c;
  assign hrdata     = rdata_c;
  assign fifo_count = count;
  assign irq_af     = (count >= AF_THR);
  assign irq_ne     = !empty;

endmodule

// File: tb/tb_ahb_fifo_slave_v2.sv
module tb_ahb_fifo_slave_v2;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [4:0]  fifo_count;
  logic        irq_af;
  logic        irq_ne;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] rd;
  logic [1:0]  rsp;
  int          wt, ec;

  always #5 hclk = ~hclk;

  // Single slave on the bus: the bus ready is this slave's ready.
  assign hready = hready_out;

  ahb_fifo_slave_v2 dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hready     (hready),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .fifo_count (fifo_count),
    .irq_af     (irq_af),
    .irq_ne     (irq_ne)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Non-pipelined transfer. Called #1 after a rising edge with the slave idle;
  // returns #1 after the edge that completes the data phase.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wd, output logic [31:0] rdo,
                      output logic [1:0] rspo, output int waits, output int err1);
    int guard;
    waits = 0;
    err1  = 0;
    guard = 0;
    hsel = 1'b1; htrans = T_NONSEQ; haddr = addr; hwrite = wr; hsize = size;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = T_IDLE; hwdata = wd;
    while (hready_out !== 1'b1 && guard < 100) begin
      if (hresp == 2'b00) waits++;
      else err1++;
      guard++;
      @(posedge hclk); #1;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_mis++;
      $error("FAIL xfer_bound: observed %0d stall cycles expected fewer than 100", guard);
    end
    rdo  = hrdata;
    rspo = hresp;
    @(posedge hclk); #1;
  endtask

  initial begin
    hreset = 1'b0; hsel = 1'b0; haddr = '0; htrans = T_IDLE;
    hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    #1;
    chk("rst_ready", hready_out, 1);
    chk("rst_resp", hresp, 0);
    chk("rst_rdata", hrdata, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_irq", {irq_af, irq_ne}, 0);
    @(posedge hclk); @(posedge hclk); #1;
    hreset = 1'b1;

    // Three back-to-back NONSEQ DATA writes.
    hsel = 1'b1; htrans = T_NONSEQ; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge hclk); #1;
      hwdata = 32'hA1 + 32'(i);
      if (i == 2) begin hsel = 1'b0; htrans = T_IDLE; end
      chk("b2b_wr_ready", hready_out, 1);
      chk("b2b_wr_resp", hresp, 0);
    end
    @(posedge hclk); #1;
    chk("b2b_wr_count", fifo_count, 3);
    chk("b2b_wr_ne", irq_ne, 1);

    // Three back-to-back DATA reads, in order.
    hsel = 1'b1; htrans = T_NONSEQ; haddr = 32'h0; hwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge hclk); #1;
      if (i == 2) begin hsel = 1'b0; htrans = T_IDLE; end
      chk("b2b_rd_ready", hready_out, 1);
      chk("b2b_rd_data", hrdata, 32'hA1 + 32'(i));
    end
    @(posedge hclk); #1;
    chk("b2b_rd_count", fifo_count, 0);
    chk("b2b_rd_ne", irq_ne, 0);

    // BUSY while selected has no effect.
    hsel = 1'b1; htrans = T_BUSY; haddr = 32'h0; hwrite = 1'b1; hwdata = 32'h77;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = T_IDLE;
    chk("busy_ready", hready_out, 1);
    @(posedge hclk); #1;
    chk("busy_count", fifo_count, 0);

    // Fill to 11: not yet almost full.
    for (int i = 0; i < 11; i++) xfer(32'h0, 1'b1, 3'd2, 32'h100 + 32'(i), rd, rsp, wt, ec);
    chk("af_below", irq_af, 0);
    xfer(32'h0, 1'b1, 3'd2, 32'h10B, rd, rsp, wt, ec);
    chk("af_at12", irq_af, 1);
    xfer(32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("stat12_word", rd, 32'h08C);
    chk("stat12_resp", rsp, 0);
    xfer(32'h4, 1'b1, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("wr_status_resp", rsp, 1);
    chk("wr_status_err1", ec, 1);
    chk("wr_status_count", fifo_count, 12);

    // Fill to depth, then one more write times out.
    for (int i = 12; i < 16; i++) xfer(32'h0, 1'b1, 3'd2, 32'h100 + 32'(i), rd, rsp, wt, ec);
    chk("full_count", fifo_count, 16);
    xfer(32'h0, 1'b1, 3'd2, 32'hDEAD, rd, rsp, wt, ec);
    chk("ovf_waits", wt, 16);
    chk("ovf_err1", ec, 1);
    chk("ovf_resp", rsp, 1);
    chk("ovf_count", fifo_count, 16);
    xfer(32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("ovf_stat", rd, 32'h2D0);
    xfer(32'h0, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("head_after_ovf", rd, 32'h100);
    chk("head_waits", wt, 0);
    chk("pop_count", fifo_count, 15);

    // Flush only: sticky ovf survives.
    xfer(32'h8, 1'b1, 3'd2, 32'h1, rd, rsp, wt, ec);
    chk("flush_resp", rsp, 0);
    chk("flush_count", fifo_count, 0);
    xfer(32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("flush_stat", rd, 32'h220);

    // Empty read times out.
    xfer(32'h0, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("udf_waits", wt, 16);
    chk("udf_err1", ec, 1);
    chk("udf_resp", rsp, 1);
    chk("udf_rdata", rd, 0);
    xfer(32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("udf_stat", rd, 32'h320);

    // Five entries, then CTRL=3 flushes and clears flags.
    for (int i = 0; i < 5; i++) xfer(32'h0, 1'b1, 3'd2, 32'h200 + 32'(i), rd, rsp, wt, ec);
    xfer(32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("five_stat", rd, 32'h305);
    xfer(32'h8, 1'b1, 3'd2, 32'h3, rd, rsp, wt, ec);
    chk("ctrl3_count", fifo_count, 0);
    chk("ctrl3_ne", irq_ne, 0);
    xfer(32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("ctrl3_stat", rd, 32'h020);

    // Decode errors.
    xfer(32'h0, 1'b1, 3'd0, 32'h55, rd, rsp, wt, ec);
    chk("byte_resp", rsp, 1);
    chk("byte_err1", ec, 1);
    chk("byte_count", fifo_count, 0);
    xfer(32'h8, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("rd_ctrl_resp", rsp, 1);
    xfer(32'hC, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("unmapped_resp", rsp, 1);
    xfer(32'h2, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("unaligned_resp", rsp, 1);

    // Reset asserted in the middle of a stalled empty read.
    hsel = 1'b1; htrans = T_NONSEQ; haddr = 32'h0; hwrite = 1'b0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = T_IDLE;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    chk("midwait_ready", hready_out, 0);
    hreset = 1'b0;
    #1;
    chk("rstwait_ready", hready_out, 1);
    chk("rstwait_resp", hresp, 0);
    chk("rstwait_rdata", hrdata, 0);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    xfer(32'h0, 1'b1, 3'd2, 32'h55, rd, rsp, wt, ec);
    chk("post_rst_count", fifo_count, 1);
    xfer(32'h0, 1'b0, 3'd2, 32'h0, rd, rsp, wt, ec);
    chk("post_rst_data", rd, 32'h55);
    chk("post_rst_resp", rsp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
